mem_opnd_sched: RTL and testbench
=================================

Name: mem_opnd_sched

Overview:
Sequences the memory-operand traffic for one decoded instruction over a single shared memory port. Per instruction it performs up to two operand reads (opnd0, then opnd1, e.g. MOVS/CMPS) and presents the size-masked values to execute. It then performs at most one writeback store and signals completion. It sits between operand decode (memory flags and effective addresses) and the memory interface, and supplies the memory-operand values to the operand selection mux.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width (operand values are DATA_W wide)
TIMEOUT_CYCLES, 255, response watchdog limit (used only with MEM_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  decoded instruction valid (accepted only in IDLE)
opnd0_is_mem  in  1  operand#0 is a memory operand
opnd1_is_mem  in  1  operand#1 is a memory operand
opnd0_addr  in  ADDR_W  operand#0 effective address
opnd1_addr  in  ADDR_W  operand#1 effective address
opnd_size  in  2  00=byte, 01=word, 10=dword, 11=dword
wb_en  in  1  instruction writes its result to memory
wb_addr  in  ADDR_W  writeback address
exec_ack  in  1  execute has consumed the operands
wb_data  in  DATA_W  result to store (sampled on exec_ack)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=write, 0=read
mem_req_addr  out  ADDR_W  request address
mem_req_wdata  out  DATA_W  write data
mem_req_size  out  2  latched opnd_size
mem_rsp_valid  in  1  read response valid
mem_rsp_data  in  DATA_W  read response data
opnd0_memval  out  DATA_W  captured operand#0 value
opnd1_memval  out  DATA_W  captured operand#1 value
opnds_valid  out  1  operand values stable, awaiting exec_ack
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  watchdog fired (sticky until next accepted start)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including memvals, address/data/size and err.
- start in IDLE latches all instruction inputs, clears err, and clears both memvals. start in any other state is ignored.
- States: IDLE, RD0_REQ, RD0_WAIT, RD1_REQ, RD1_WAIT, OPND_RDY, WB_REQ, DONE.
- Transitions out of IDLE on start: RD0_REQ if opnd0_is_mem; else RD1_REQ if opnd1_is_mem; else OPND_RDY.
- RDx_REQ: mem_req_valid=1, we=0, addr=opndx_addr. On valid&&ready, go to RDx_WAIT.
- mem_req_valid and its payload must stay stable until ready. A request is never withdrawn.
- RD0_WAIT: on mem_rsp_valid, capture data into opnd0_memval. Go to RD1_REQ if opnd1_is_mem, else OPND_RDY.
- RD1_WAIT: on mem_rsp_valid, capture into opnd1_memval, then go to OPND_RDY.
- mem_rsp_valid outside a WAIT state is ignored.
- Captured data is zero-extended from the low 8/16/32 bits per size: byte masks [7:0], word masks [15:0], dword and 11 take the full value.
- OPND_RDY: opnds_valid=1; memvals hold. On exec_ack, go to WB_REQ if wb_en (wb_data latched that cycle), else DONE.
- WB_REQ: valid=1, we=1, addr=wb_addr, wdata=wb_data masked to size. On handshake, go to DONE. Writes get no response.
- DONE: done=1 for one cycle, then IDLE. Memvals hold until the next start.
- Best-case latency (ready=1, response one cycle after acceptance), with start at cycle 0:
  - two reads: opnds_valid at cycle 5
  - one read: cycle 3
  - no memory: cycle 1
- mem_req_valid never asserts in IDLE, OPND_RDY or DONE.

Optional Feature:
MEM_SCHED_TIMEOUT_EN
- Defined: an 8-bit-minimum counter clears on entry to each WAIT state and increments every WAIT cycle without mem_rsp_valid. When it reaches TIMEOUT_CYCLES, set err, skip the remaining reads and writeback, and go to DONE (done still pulses).
- Undefined: no counter and no timeout path. WAIT states wait indefinitely, and err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 mid RD0_WAIT, release -> state IDLE, all outputs 0, and a later mem_rsp_valid is ignored.
- Two-read MOVS: opnd0_addr=0x1000, opnd1_addr=0x2000, size=10, ready=1, responses 0xDEADBEEF/0x12345678 -> reads issued in order 0x1000 then 0x2000, memvals match, opnds_valid at cycle 5.
- Byte masking plus writeback: opnd0 read, size=00, rsp 0xAABBCCDD, wb_en=1, wb_addr=0x3000, wb_data=0x11223344 -> opnd0_memval=0xDD, then a write to 0x3000 with wdata=0x44, then done.
- Backpressure: ready=0 for 4 cycles in RD0_REQ -> valid/addr stable throughout. A start pulsed during the stall is ignored. Exactly one read is accepted.
- No memory operands: start with both flags 0 and wb_en=0 -> opnds_valid at cycle 1, no memory request, done one cycle after exec_ack.
- Timeout (macro defined, TIMEOUT_CYCLES=4): no response in RD0_WAIT -> err=1 after 4 cycles, done pulses, no RD1 request. The next start clears err.

Source files
------------

// File: rtl/mem_opnd_sched.sv
// Memory-operand scheduler: up to two operand reads, then one optional writeback, over one shared port.
// Optional response watchdog enabled by defining MEM_SCHED_TIMEOUT_EN.
module mem_opnd_sched #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              opnd0_is_mem,
  input  logic              opnd1_is_mem,
  input  logic [ADDR_W-1:0] opnd0_addr,
  input  logic [ADDR_W-1:0] opnd1_addr,
  input  logic [1:0]        opnd_size,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              exec_ack,
  input  logic [DATA_W-1:0] wb_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [1:0]        mem_req_size,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [DATA_W-1:0] opnd0_memval,
  output logic [DATA_W-1:0] opnd1_memval,
  output logic              opnds_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0_REQ, S_RD0_WAIT, S_RD1_REQ, S_RD1_WAIT, S_OPND_RDY, S_WB_REQ, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                op1_mem_q, op1_mem_d;
  logic [ADDR_W-1:0]   a0_q, a0_d, a1_q, a1_d, wba_q, wba_d;
  logic [1:0]          size_q, size_d;
  logic                wb_en_q, wb_en_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, mv0_q, mv0_d, mv1_q, mv1_d;

  function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] v, input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {{(DATA_W-8){1'b0}}, v[7:0]};
      2'b01:   r = {{(DATA_W-16){1'b0}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    op1_mem_d     = op1_mem_q;
    a0_d          = a0_q;
    a1_d          = a1_q;
    wba_d         = wba_q;
    size_d        = size_q;
    wb_en_d       = wb_en_q;
    wdata_d       = wdata_q;
    mv0_d         = mv0_q;
    mv1_d         = mv1_q;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    opnds_valid   = 1'b0;
    done          = 1'b0;
`ifdef MEM_SCHED_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        op1_mem_d = opnd1_is_mem;
        a0_d      = opnd0_addr;
        a1_d      = opnd1_addr;
        wba_d     = wb_addr;
        size_d    = opnd_size;
        wb_en_d   = wb_en;
        mv0_d     = '0;
        mv1_d     = '0;
`ifdef MEM_SCHED_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        if (opnd0_is_mem)      state_d = S_RD0_REQ;
        else if (opnd1_is_mem) state_d = S_RD1_REQ;
        else                   state_d = S_OPND_RDY;
      end
      S_RD0_REQ, S_RD1_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = (state_q == S_RD0_REQ) ? a0_q : a1_q;
        if (mem_req_ready) begin
          state_d = (state_q == S_RD0_REQ) ? S_RD0_WAIT : S_RD1_WAIT;
`ifdef MEM_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RD0_WAIT, S_RD1_WAIT: begin
        if (mem_rsp_valid) begin
          if (state_q == S_RD0_WAIT) begin
            mv0_d   = size_mask(mem_rsp_data, size_q);
            state_d = op1_mem_q ? S_RD1_REQ : S_OPND_RDY;
          end else begin
            mv1_d   = size_mask(mem_rsp_data, size_q);
            state_d = S_OPND_RDY;
          end
        end
`ifdef MEM_SCHED_TIMEOUT_EN
        // Watchdog abandons the rest of the instruction but still pulses done.
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_OPND_RDY: begin
        opnds_valid = 1'b1;
        if (exec_ack) begin
          wdata_d = size_mask(wb_data, size_q);
          state_d = wb_en_q ? S_WB_REQ : S_DONE;
        end
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = wba_q;
        mem_req_wdata = wdata_q;
        if (mem_req_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op1_mem_q <= 1'b0;
      a0_q      <= '0;
      a1_q      <= '0;
      wba_q     <= '0;
      size_q    <= '0;
      wb_en_q   <= 1'b0;
      wdata_q   <= '0;
      mv0_q     <= '0;
      mv1_q     <= '0;
`ifdef MEM_SCHED_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op1_mem_q <= op1_mem_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      wba_q     <= wba_d;
      size_q    <= size_d;
      wb_en_q   <= wb_en_d;
      wdata_q   <= wdata_d;
      mv0_q     <= mv0_d;
      mv1_q     <= mv1_d;
`ifdef MEM_SCHED_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign mem_req_size = size_q;
  assign opnd0_memval = mv0_q;
  assign opnd1_memval = mv1_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_opnd_sched.sv
// Directed bench for mem_opnd_sched: vector table plus reset, backpressure and timeout sequences.
module tb_mem_opnd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, opnd0_is_mem, opnd1_is_mem, wb_en, exec_ack;
  logic [31:0] opnd0_addr, opnd1_addr, wb_addr, wb_data;
  logic [1:0]  opnd_size;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [1:0]  mem_req_size;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] opnd0_memval, opnd1_memval;
  logic        opnds_valid, busy, done, err;

  always #5 clk = ~clk;

  mem_opnd_sched #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opnd0_is_mem(opnd0_is_mem), .opnd1_is_mem(opnd1_is_mem),
    .opnd0_addr(opnd0_addr), .opnd1_addr(opnd1_addr), .opnd_size(opnd_size),
    .wb_en(wb_en), .wb_addr(wb_addr), .exec_ack(exec_ack), .wb_data(wb_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .opnd0_memval(opnd0_memval), .opnd1_memval(opnd1_memval),
    .opnds_valid(opnds_valid), .busy(busy), .done(done), .err(err)
  );

  // Memory model: answers each accepted read one cycle later and logs all accepted requests.
  int          cyc = 0;
  logic [31:0] rd_log[$];
  int          wr_cnt = 0;
  logic [31:0] wr_addr_last = '0, wr_data_last = '0;
  logic        rsp_en = 1'b1, rsp_force = 1'b0;
  logic [31:0] force_data = '0, cur_a0 = '0, cur_rsp0 = '0, cur_rsp1 = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_we) begin
        wr_cnt       <= wr_cnt + 1;
        wr_addr_last <= mem_req_addr;
        wr_data_last <= mem_req_wdata;
      end else begin
        rd_log.push_back(mem_req_addr);
      end
    end
    mem_rsp_valid <= rsp_force || (rsp_en && mem_req_valid && mem_req_ready && !mem_req_we);
    mem_rsp_data  <= rsp_force ? force_data :
                     (mem_req_addr == cur_a0) ? cur_rsp0 : cur_rsp1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {mem_req_valid | mem_req_we | mem_req_size[0] | mem_req_size[1] | opnds_valid |
            busy | done | err | (|mem_req_addr) | (|mem_req_wdata) | (|opnd0_memval),
            opnd1_memval};
  endfunction

  typedef struct {
    logic        op0, op1;
    logic [31:0] a0, a1;
    logic [1:0]  size;
    logic        wb;
    logic [31:0] wba, wbd, rsp0, rsp1;
    logic [31:0] exp_mv0, exp_mv1, exp_wdata;
    int          exp_lat, exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic drive_start(input logic op0, input logic op1, input logic [31:0] a0,
                             input logic [31:0] a1, input logic [1:0] sz, input logic wb,
                             input logic [31:0] wba);
    opnd0_is_mem = op0; opnd1_is_mem = op1; opnd0_addr = a0; opnd1_addr = a1;
    opnd_size = sz; wb_en = wb; wb_addr = wba; start = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, lat, rd_base, wr_base;
    bit got;
    rd_base = rd_log.size();
    wr_base = wr_cnt;
    cur_a0 = v.a0; cur_rsp0 = v.rsp0; cur_rsp1 = v.rsp1;
    @(negedge clk);
    drive_start(v.op0, v.op1, v.a0, v.a1, v.size, v.wb, v.wba);
    n = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("memvals_cleared", {opnd0_memval, opnd1_memval}, 64'h0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (opnds_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk("opnds_valid_reached", got, 1'b1);
    lat = cyc - n;
    chk("latency", lat, v.exp_lat);
    chk("opnd0_memval", opnd0_memval, v.exp_mv0);
    chk("opnd1_memval", opnd1_memval, v.exp_mv1);
    chk("req_size", mem_req_size, v.size);
    chk("no_req_in_opnd_rdy", mem_req_valid, 1'b0);
    chk("read_count", rd_log.size() - rd_base, v.exp_rd);
    if (v.op0) chk("first_read_addr", rd_log[rd_base], v.a0);
    if (v.op1) chk("last_read_addr", rd_log[rd_log.size()-1], v.a1);
    exec_ack = 1'b1; wb_data = v.wbd;
    @(negedge clk);
    exec_ack = 1'b0; wb_data = 32'hFFFF_FFFF;
    if (!v.wb) chk("done_after_ack", done, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    chk("done_reached", got, 1'b1);
    chk("write_count", wr_cnt - wr_base, v.wb ? 1 : 0);
    if (v.wb) begin
      chk("wb_addr", wr_addr_last, v.wba);
      chk("wb_wdata", wr_data_last, v.exp_wdata);
    end
    @(negedge clk);
    chk("done_one_cycle", {done, busy}, 2'b00);
    $display("txn %0d: lat=%0d mv0=0x%08h mv1=0x%08h reads=%0d writes=%0d",
             idx, lat, opnd0_memval, opnd1_memval, rd_log.size() - rd_base, wr_cnt - wr_base);
  endtask

  initial begin
    vecs[0] = '{1,1,32'h1000,32'h2000,2'b10,0,32'h0,32'h0,32'hDEADBEEF,32'h12345678,
                32'hDEADBEEF,32'h12345678,32'h0,5,2};
    vecs[1] = '{1,0,32'h1100,32'h0,2'b00,1,32'h3000,32'h11223344,32'hAABBCCDD,32'h0,
                32'h000000DD,32'h0,32'h00000044,3,1};
    vecs[2] = '{0,0,32'h0,32'h0,2'b10,0,32'h0,32'h0,32'h0,32'h0,
                32'h0,32'h0,32'h0,1,0};
    vecs[3] = '{0,1,32'h0,32'h4000,2'b01,1,32'h5000,32'h87654321,32'h0,32'hCAFEF00D,
                32'h0,32'h0000F00D,32'h00004321,3,1};
    vecs[4] = '{1,1,32'h1234,32'h5678,2'b11,1,32'h6000,32'hA5A5A5A5,32'h80000001,32'hFFFF00FF,
                32'h80000001,32'hFFFF00FF,32'hA5A5A5A5,5,2};

    rst_n = 1'b0; start = 0; opnd0_is_mem = 0; opnd1_is_mem = 0; opnd0_addr = 0;
    opnd1_addr = 0; opnd_size = 0; wb_en = 0; wb_addr = 0; exec_ack = 0; wb_data = 0;
    mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 64'h0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Backpressure: four stalled cycles in RD0_REQ, with a stray start in the middle.
    begin
      int rd_base;
      rd_base = rd_log.size();
      cur_a0 = 32'h7000; cur_rsp0 = 32'h0BADF00D;
      mem_req_ready = 1'b0;
      drive_start(1, 0, 32'h7000, 32'h0, 2'b10, 0, 32'h0);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("stall_valid_addr", {mem_req_valid, mem_req_we, mem_req_addr}, {2'b10, 32'h7000});
        if (k == 1) drive_start(0, 1, 32'h9999, 32'h8888, 2'b00, 1, 32'h1);
        @(negedge clk);
        start = 1'b0;
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("stall_accepted", busy, 1'b1);
      @(negedge clk);
      chk("stall_opnds_valid", opnds_valid, 1'b1);
      chk("stall_read_count", rd_log.size() - rd_base, 1);
      chk("stall_memval", {opnd0_memval, opnd1_memval}, {32'h0BADF00D, 32'h0});
      exec_ack = 1'b1;
      @(negedge clk);
      exec_ack = 1'b0;
      chk("stall_done", {done, mem_req_valid}, 2'b10);
      @(negedge clk);
      $display("txn backpressure: reads=%0d mv0=0x%08h", rd_log.size() - rd_base, opnd0_memval);
    end

    // Reset asserted while waiting on a read response.
    begin
      rsp_en = 1'b0;
      cur_a0 = 32'hA000;
      drive_start(1, 1, 32'hA000, 32'hB000, 2'b10, 1, 32'hC000);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rd0_wait_busy", {busy, mem_req_valid}, 2'b10);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_force = 1'b1; force_data = 32'h55AA55AA;
      @(negedge clk);
      rsp_force = 1'b0;
      @(negedge clk);
      chk("stray_rsp_ignored", all_outs(), 64'h0);
      rsp_en = 1'b1;
      $display("txn reset_mid_wait: busy=%0b mv0=0x%08h", busy, opnd0_memval);
    end

`ifdef MEM_SCHED_TIMEOUT_EN
    begin
      int rd_base;
      rd_base = rd_log.size();
      rsp_en = 1'b0;
      drive_start(1, 1, 32'hD000, 32'hE000, 2'b10, 1, 32'hF000);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("timeout_still_wait", {busy, done, err}, 3'b100);
      @(negedge clk);
      chk("timeout_done_err", {done, err}, 2'b11);
      chk("timeout_reads", rd_log.size() - rd_base, 1);
      @(negedge clk);
      chk("timeout_err_sticky", {busy, err}, 2'b01);
      rsp_en = 1'b1;
      drive_start(0, 0, 32'h0, 32'h0, 2'b10, 0, 32'h0);
      @(negedge clk);
      start = 1'b0;
      chk("err_cleared_by_start", {opnds_valid, err}, 2'b10);
      exec_ack = 1'b1;
      @(negedge clk);
      exec_ack = 1'b0;
      @(negedge clk);
      chk("timeout_no_writes", wr_cnt, 3);
      $display("txn timeout: reads=%0d err_after_restart=%0b", rd_log.size() - rd_base, err);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
